// File: rtl/input_vc_buffer.sv
// input_vc_buffer: per-virtual-channel flit buffering for one router input port.
//
// Each VC owns a circular FIFO of VC_DEPTH slots with its own read pointer,
// write pointer and occupancy counter. The head slot of every VC is exposed
// for the downstream routing / switch-allocation stages. Each accepted pop
// returns one registered credit to the upstream router.
//
// Optional feature macro: INPUT_VC_BYPASS_EN
//   When defined, a flit pushed into an empty VC appears on vc_head_o /
//   vc_head_vld_o in the same cycle and may be consumed by a same-cycle pop.
//   When undefined (default), a pushed flit appears one cycle after the push.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   flit_vld_i      incoming flit valid
//   flit_i          incoming decoded flit
//   flit_vc_id_i    target VC of incoming flit
//   vc_head_vld_o   per-VC head valid (VC non-empty)
//   vc_head_o       per-VC head flit
//   pop_vld_i       dequeue request from the switch allocator
//   pop_vc_id_i     VC being dequeued
//   credit_vld_o    registered credit return to upstream
//   credit_vc_id_o  VC of the returned credit
//   vc_full_o       per-VC full flag
//   err_overflow_o  sticky: a push to a full VC was dropped
module input_vc_buffer #(
  parameter int unsigned VC_NUM   = 4,
  parameter int unsigned VC_DEPTH = 4,
  parameter type         flit_dec_t = logic [31:0]
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flit_vld_i,
  input  flit_dec_t                                 flit_i,
  input  logic [$clog2(VC_NUM)-1:0]                 flit_vc_id_i,
  output logic [VC_NUM-1:0]                         vc_head_vld_o,
  output logic [VC_NUM-1:0][$bits(flit_dec_t)-1:0]  vc_head_o,
  input  logic                                      pop_vld_i,
  input  logic [$clog2(VC_NUM)-1:0]                 pop_vc_id_i,
  output logic                                      credit_vld_o,
  output logic [$clog2(VC_NUM)-1:0]                 credit_vc_id_o,
  output logic [VC_NUM-1:0]                         vc_full_o,
  output logic                                      err_overflow_o
);

  localparam int unsigned VcW   = $clog2(VC_NUM);
  localparam int unsigned PtrW  = $clog2(VC_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned FlitW = $bits(flit_dec_t);
  localparam logic [CntW-1:0] DepthCnt = CntW'(VC_DEPTH);

  // Flit storage is intentionally not reset; pointers define validity.
  logic [FlitW-1:0] mem_q    [VC_NUM][VC_DEPTH];
  logic [PtrW-1:0]  rd_ptr_q [VC_NUM];
  logic [PtrW-1:0]  wr_ptr_q [VC_NUM];
  logic [CntW-1:0]  cnt_q    [VC_NUM];

  logic             credit_vld_q;
  logic [VcW-1:0]   credit_vc_id_q;
  logic             err_overflow_q;

  logic [VC_NUM-1:0] push_req;
  logic [VC_NUM-1:0] pop_req;
  logic [VC_NUM-1:0] full;
  logic [VC_NUM-1:0] empty;
  logic [VC_NUM-1:0] head_vld;
  logic [VC_NUM-1:0] push_acc;
  logic [VC_NUM-1:0] pop_acc;
  logic [VC_NUM-1:0] overflow;

  // Per-VC request decode and status.
  always_comb begin
    push_req = '0;
    pop_req  = '0;
    full     = '0;
    empty    = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      push_req[v] = flit_vld_i && (flit_vc_id_i == VcW'(v));
      pop_req[v]  = pop_vld_i && (pop_vc_id_i == VcW'(v));
      full[v]     = (cnt_q[v] == DepthCnt);
      empty[v]    = (cnt_q[v] == '0);
    end
  end

  // Head presentation.
  always_comb begin
    head_vld  = '0;
    vc_head_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
`ifdef INPUT_VC_BYPASS_EN
      // An empty VC forwards the incoming flit straight to its head.
      head_vld[v]  = !empty[v] || push_req[v];
      vc_head_o[v] = empty[v] ? FlitW'(flit_i) : mem_q[v][rd_ptr_q[v]];
`else
      head_vld[v]  = !empty[v];
      vc_head_o[v] = mem_q[v][rd_ptr_q[v]];
`endif
    end
  end

  // A full VC still accepts a push when it is popped in the same cycle.
  // In bypass mode an empty VC with push+pop advances both pointers and keeps
  // its count at zero, which is exactly "the popped flit was the bypassed one".
  always_comb begin
    pop_acc  = pop_req & head_vld;
    push_acc = push_req & (~full | pop_acc);
    overflow = push_req & full & ~pop_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      credit_vld_q   <= 1'b0;
      credit_vc_id_q <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (push_acc[v]) begin
          wr_ptr_q[v] <= wr_ptr_q[v] + PtrW'(1);
        end
        if (pop_acc[v]) begin
          rd_ptr_q[v] <= rd_ptr_q[v] + PtrW'(1);
        end
        if (push_acc[v] && !pop_acc[v]) begin
          cnt_q[v] <= cnt_q[v] + CntW'(1);
        end else if (pop_acc[v] && !push_acc[v]) begin
          cnt_q[v] <= cnt_q[v] - CntW'(1);
        end
      end
      // At most one pop per cycle, so one credit per accepted pop.
      credit_vld_q <= |pop_acc;
      if (|pop_acc) begin
        credit_vc_id_q <= pop_vc_id_i;
      end
      if (|overflow) begin
        err_overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (!rst && push_acc[v]) begin
        mem_q[v][wr_ptr_q[v]] <= FlitW'(flit_i);
      end
    end
  end

  always_comb begin
    vc_head_vld_o  = head_vld;
    vc_full_o      = full;
    credit_vld_o   = credit_vld_q;
    credit_vc_id_o = credit_vc_id_q;
    err_overflow_o = err_overflow_q;
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
module tb_input_vc_buffer;

  localparam int VC_NUM   = 4;
  localparam int VC_DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flit_vld_i;
  logic [31:0]            flit_i;
  logic [1:0]             flit_vc_id_i;
  logic [VC_NUM-1:0]      vc_head_vld_o;
  logic [VC_NUM-1:0][31:0] vc_head_o;
  logic                   pop_vld_i;
  logic [1:0]             pop_vc_id_i;
  logic                   credit_vld_o;
  logic [1:0]             credit_vc_id_o;
  logic [VC_NUM-1:0]      vc_full_o;
  logic                   err_overflow_o;

  input_vc_buffer #(
    .VC_NUM   (VC_NUM),
    .VC_DEPTH (VC_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_vld_i     (flit_vld_i),
    .flit_i         (flit_i),
    .flit_vc_id_i   (flit_vc_id_i),
    .vc_head_vld_o  (vc_head_vld_o),
    .vc_head_o      (vc_head_o),
    .pop_vld_i      (pop_vld_i),
    .pop_vc_id_i    (pop_vc_id_i),
    .credit_vld_o   (credit_vld_o),
    .credit_vc_id_o (credit_vc_id_o),
    .vc_full_o      (vc_full_o),
    .err_overflow_o (err_overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue of flits per VC plus expected side outputs.
  logic [31:0] m_q [VC_NUM][$];
  bit          m_err;
  bit          m_cred;
  int          m_cred_id;

  task automatic model_clear();
    for (int v = 0; v < VC_NUM; v++) m_q[v].delete();
    m_err  = 0;
    m_cred = 0;
    m_cred_id = 0;
  endtask

  // One clock cycle with the given push/pop request; model follows the rules
  // of acceptance, then outputs are sampled 1 time unit after the edge.
  task automatic step(input bit push, input int pvc, input logic [31:0] f,
                      input bit pop, input int ovc);
    bit pop_ok;
    bit push_ok;
    flit_vld_i   = push;
    flit_vc_id_i = 2'(pvc);
    flit_i       = f;
    pop_vld_i    = pop;
    pop_vc_id_i  = 2'(ovc);
    pop_ok  = pop && (m_q[ovc].size() > 0);
    push_ok = push && ((m_q[pvc].size() < VC_DEPTH) || (pop_ok && ovc == pvc));
    @(posedge clk);
    #1;
    flit_vld_i = 1'b0;
    pop_vld_i  = 1'b0;
    m_cred = pop_ok;
    if (pop_ok) begin
      m_cred_id = ovc;
      void'(m_q[ovc].pop_front());
    end
    if (push && !push_ok) m_err = 1;
    if (push_ok) m_q[pvc].push_back(f);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flit_vld_i = 1'b0;
    pop_vld_i  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flit_vld_i = 1'b1;
    flit_i = $urandom;
    flit_vc_id_i = 2'($urandom_range(0, 3));
    pop_vld_i = 1'b1;
    pop_vc_id_i = 2'($urandom_range(0, 3));
    repeat (2) @(posedge clk);
    #1;
    flit_vld_i = 1'b0;
    pop_vld_i = 1'b0;
    n_checks++;
    if (vc_head_vld_o !== 4'b0000 || vc_full_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_status got vld=%b full=%b exp 0000/0000", vc_head_vld_o, vc_full_o);
    end
    n_checks++;
    if (credit_vld_o !== 1'b0 || credit_vc_id_o !== 2'd0 || err_overflow_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_credit_err got cv=%b cid=%0d err=%b exp 0/0/0",
               credit_vld_o, credit_vc_id_o, err_overflow_o);
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_push_head();
    logic [31:0] a;
    do_reset();
    a = $urandom;
    step(1, 1, a, 0, 0);
    n_checks++;
    if (vc_head_vld_o !== 4'b0010) begin
      n_errors++;
      $display("FAIL push_head_vld got %b exp 0010", vc_head_vld_o);
    end
    n_checks++;
    if (vc_head_o[1] !== a) begin
      n_errors++;
      $display("FAIL push_head_data got %h exp %h", vc_head_o[1], a);
    end
    step(0, 0, 0, 1, 1);
    n_checks++;
    if (credit_vld_o !== 1'b1 || credit_vc_id_o !== 2'd1 || vc_head_vld_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL push_head_pop got cv=%b cid=%0d vld=%b exp 1/1/0000",
               credit_vld_o, credit_vc_id_o, vc_head_vld_o);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] f [5];
    do_reset();
    for (int i = 0; i < 5; i++) f[i] = $urandom;
    for (int i = 0; i < 4; i++) step(1, 0, f[i], 0, 0);
    n_checks++;
    if (vc_full_o !== 4'b0001 || err_overflow_o !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_fill got full=%b err=%b exp 0001/0", vc_full_o, err_overflow_o);
    end
    step(1, 0, f[4], 0, 0);
    n_checks++;
    if (vc_full_o !== 4'b0001 || err_overflow_o !== 1'b1 || vc_head_o[0] !== f[0]) begin
      n_errors++;
      $display("FAIL ovf_drop got full=%b err=%b head=%h exp 0001/1/%h",
               vc_full_o, err_overflow_o, vc_head_o[0], f[0]);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (vc_head_vld_o[0] !== 1'b1 || vc_head_o[0] !== f[i]) begin
        n_errors++;
        $display("FAIL ovf_drain[%0d] got vld=%b head=%h exp 1/%h",
                 i, vc_head_vld_o[0], vc_head_o[0], f[i]);
      end
      step(0, 0, 0, 1, 0);
    end
    n_checks++;
    if (vc_head_vld_o[0] !== 1'b0 || err_overflow_o !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_empty got vld=%b err=%b exp 0/1", vc_head_vld_o[0], err_overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] f [5];
    do_reset();
    for (int i = 0; i < 5; i++) f[i] = $urandom;
    for (int i = 0; i < 4; i++) step(1, 2, f[i], 0, 0);
    step(1, 2, f[4], 1, 2);
    n_checks++;
    if (vc_full_o !== 4'b0100 || err_overflow_o !== 1'b0) begin
      n_errors++;
      $display("FAIL full_pp_status got full=%b err=%b exp 0100/0", vc_full_o, err_overflow_o);
    end
    n_checks++;
    if (credit_vld_o !== 1'b1 || credit_vc_id_o !== 2'd2) begin
      n_errors++;
      $display("FAIL full_pp_credit got cv=%b cid=%0d exp 1/2", credit_vld_o, credit_vc_id_o);
    end
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (vc_head_vld_o[2] !== 1'b1 || vc_head_o[2] !== f[i]) begin
        n_errors++;
        $display("FAIL full_pp_order[%0d] got vld=%b head=%h exp 1/%h",
                 i, vc_head_vld_o[2], vc_head_o[2], f[i]);
      end
      step(0, 0, 0, 1, 2);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] sent [10];
    int credits;
    do_reset();
    credits = 0;
    for (int i = 0; i < 10; i++) sent[i] = $urandom;
    step(1, 3, sent[0], 0, 0);
    for (int i = 1; i < 11; i++) begin
      n_checks++;
      if (vc_head_vld_o[3] !== 1'b1 || vc_head_o[3] !== sent[i-1]) begin
        n_errors++;
        $display("FAIL wrap_order[%0d] got vld=%b head=%h exp 1/%h",
                 i - 1, vc_head_vld_o[3], vc_head_o[3], sent[i-1]);
      end
      if (i < 10) step(1, 3, sent[i], 1, 3);
      else step(0, 0, 0, 1, 3);
      if (credit_vld_o === 1'b1 && credit_vc_id_o === 2'd3) credits++;
    end
    n_checks++;
    if (credits !== 10 || vc_head_vld_o[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_credits got credits=%0d vld=%b exp 10/0", credits, vc_head_vld_o[3]);
    end
  endtask

  task automatic test_empty_pop();
    logic [31:0] x;
    do_reset();
    x = $urandom;
    step(1, 1, x, 0, 0);
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (credit_vld_o !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_pop_credit got %b exp 0", credit_vld_o);
    end
    n_checks++;
    if (vc_head_vld_o !== 4'b0010 || vc_head_o[1] !== x || vc_full_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL empty_pop_state got vld=%b head=%h full=%b exp 0010/%h/0000",
               vc_head_vld_o, vc_head_o[1], vc_full_o, x);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 1, $urandom, 0, 0);
    step(1, 1, $urandom, 0, 0);
    step(1, 0, $urandom, 0, 0);
    rst = 1'b1;
    flit_vld_i = 1'b1;
    flit_vc_id_i = 2'd1;
    flit_i = $urandom;
    pop_vld_i = 1'b1;
    pop_vc_id_i = 2'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flit_vld_i = 1'b0;
    pop_vld_i = 1'b0;
    model_clear();
    n_checks++;
    if (vc_head_vld_o !== 4'b0000 || vc_full_o !== 4'b0000 || credit_vld_o !== 1'b0 ||
        credit_vc_id_o !== 2'd0 || err_overflow_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid got vld=%b full=%b cv=%b cid=%0d err=%b exp all zero",
               vc_head_vld_o, vc_full_o, credit_vld_o, credit_vc_id_o, err_overflow_o);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (credit_vld_o !== 1'b0 || vc_head_vld_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_mid_after got cv=%b vld=%b exp 0/0000", credit_vld_o, vc_head_vld_o);
    end
  endtask

  task automatic test_random();
    logic [VC_NUM-1:0] exp_vld;
    logic [VC_NUM-1:0] exp_full;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, $urandom_range(0, 3), $urandom,
           ($urandom % 2) != 0, $urandom_range(0, 3));
      for (int v = 0; v < VC_NUM; v++) begin
        exp_vld[v]  = m_q[v].size() > 0;
        exp_full[v] = m_q[v].size() == VC_DEPTH;
      end
      n_checks++;
      if (vc_head_vld_o !== exp_vld || vc_full_o !== exp_full) begin
        n_errors++;
        $display("FAIL rand_status[%0d] got vld=%b full=%b exp %b/%b",
                 c, vc_head_vld_o, vc_full_o, exp_vld, exp_full);
      end
      for (int v = 0; v < VC_NUM; v++) begin
        if (m_q[v].size() > 0) begin
          n_checks++;
          if (vc_head_o[v] !== m_q[v][0]) begin
            n_errors++;
            $display("FAIL rand_head[%0d] vc%0d got %h exp %h", c, v, vc_head_o[v], m_q[v][0]);
          end
        end
      end
      n_checks++;
      if (credit_vld_o !== m_cred || (m_cred && credit_vc_id_o !== 2'(m_cred_id))) begin
        n_errors++;
        $display("FAIL rand_credit[%0d] got cv=%b cid=%0d exp %b/%0d",
                 c, credit_vld_o, credit_vc_id_o, m_cred, m_cred_id);
      end
      n_checks++;
      if (err_overflow_o !== m_err) begin
        n_errors++;
        $display("FAIL rand_err[%0d] got %b exp %b", c, err_overflow_o, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    flit_vld_i = 1'b0;
    flit_i = '0;
    flit_vc_id_i = '0;
    pop_vld_i = 1'b0;
    pop_vc_id_i = '0;
    model_clear();
    test_reset();
    test_push_head();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_empty_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/input_vc_buffer.md
INPUT_VC_BUFFER -- requirements
Module: input_vc_buffer

Interface
REQ-001 SHALL have parameter VC_NUM, default 4, number of virtual channels on this input port (power of two, 2..8).
REQ-002 SHALL have parameter VC_DEPTH, default 4, flit slots per VC (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flit_vld_i  input  1  incoming link flit valid.
REQ-006 SHALL have port flit_i  input  $bits(flit_dec_t)  incoming decoded flit; carries look_ahead_routing and tgt_id for the downstream look-ahead routing stage.
REQ-007 SHALL have port flit_vc_id_i  input  $clog2(VC_NUM)  target VC of incoming flit.
REQ-008 SHALL have port vc_head_vld_o  output  VC_NUM  per-VC head flit valid (VC non-empty).
REQ-009 SHALL have port vc_head_o  output  VC_NUM x $bits(flit_dec_t)  per-VC head flit; feeds vc_ctrl_head of routing/SA.
REQ-010 SHALL have port pop_vld_i  input  1  SA winner of this port dequeues a flit.
REQ-011 SHALL have port pop_vc_id_i  input  $clog2(VC_NUM)  VC being dequeued.
REQ-012 SHALL have port credit_vld_o  output  1  credit returned to upstream router.
REQ-013 SHALL have port credit_vc_id_o  output  $clog2(VC_NUM)  VC of returned credit.
REQ-014 SHALL have port vc_full_o  output  VC_NUM  per-VC full flag (debug/assertion).
REQ-015 SHALL have port err_overflow_o  output  1  sticky: write to full VC occurred.

Function
REQ-016 SHALL hold one circular FIFO per VC with read pointer, write pointer, occupancy counter of $clog2(VC_DEPTH)+1 bits.
REQ-017 SHALL accept a push when flit_vld_i=1 and target VC is not full, or is full and is popped in the same cycle.
REQ-018 SHALL drop a push to a full, not-simultaneously-popped VC, leave that VC unchanged, and set err_overflow_o next cycle.
REQ-019 SHALL dequeue on pop_vld_i=1 only if vc_head_vld_o[pop_vc_id_i]=1; a pop of an empty VC SHALL be ignored and return no credit.
REQ-020 SHALL wrap read/write pointers from VC_DEPTH-1 to 0.
REQ-021 SHALL, on simultaneous push and pop to the same VC, keep occupancy unchanged and advance both pointers.
REQ-022 SHALL, on simultaneous push and pop to different VCs, apply both independently.
REQ-023 SHALL present a pushed flit at vc_head_o with vc_head_vld_o set one cycle after the push edge (latency 1) when the VC was empty.
REQ-024 SHALL drive vc_head_o[v] from the slot at read pointer of VC v; value undefined-but-stable when vc_head_vld_o[v]=0.
REQ-025 SHALL register credit return: credit_vld_o=1 and credit_vc_id_o=popped VC exactly one cycle after each accepted pop; one credit per accepted pop, no coalescing.
REQ-026 SHALL assert vc_full_o[v] when occupancy of v equals VC_DEPTH.

Reset
REQ-027 SHALL on rst=1 clear all pointers and counters, vc_head_vld_o=0, vc_full_o=0, credit_vld_o=0, credit_vc_id_o=0, err_overflow_o=0.
REQ-028 SHALL give rst priority over push and pop in the same cycle; asserted mid-operation it discards all buffered flits and pending credits.
REQ-029 SHALL not reset flit storage contents.

Configuration
REQ-030 SHALL provide macro INPUT_VC_BYPASS_EN.
REQ-031 SHALL, with INPUT_VC_BYPASS_EN defined, present a flit pushed into an empty VC on vc_head_o/vc_head_vld_o in the same cycle (combinational bypass); a same-cycle pop of that VC SHALL consume the bypassed flit, leave the VC empty, and return a credit.
REQ-032 SHALL, without INPUT_VC_BYPASS_EN, behave per REQ-023 (no combinational path from flit_i to vc_head_o).

Verification
REQ-033 SHALL verify: reset, push flit A to VC1 -> vc_head_vld_o=4'b0010 next cycle, vc_head_o[1]=A.
REQ-034 SHALL verify: push 4 flits to VC0 (VC_DEPTH=4), 5th push without pop -> vc_full_o[0]=1, 5th dropped, err_overflow_o=1, head still 1st flit.
REQ-035 SHALL verify: VC2 full, push and pop VC2 same cycle -> push accepted, occupancy 4, credit_vld_o=1 with credit_vc_id_o=2 next cycle.
REQ-036 SHALL verify: push/pop 10 flits through VC3 -> output order matches input, pointers wrap, 10 credits returned.
REQ-037 SHALL verify: pop of empty VC0 -> no state change, credit_vld_o=0 next cycle.
REQ-038 SHALL verify: VC1 holds 2 flits, rst=1 with concurrent push/pop -> all outputs zero next cycle, no credit issued.
